// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column rotation, frame classification, press/release debounce.
// Optional decimal digit-entry shift register enabled by defining KEYPAD_DIGIT_ENTRY_EN.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3
);

  localparam int               DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0]       DEB_TARGET = 8'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  logic [3:0]       row_s1_q, row_s2_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       frame_lows_q, frame_lows_d;
  logic [3:0]       frame_code_q, frame_code_d;
  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [7:0]       count_q, count_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;

  logic       sample_en, frame_end;
  logic [2:0] col_lows, lows_sum;
  logic [3:0] col_code, merged_code;
  logic [1:0] merged_lows;
  logic       res_none, res_single;
  logic [7:0] count_inc;

  // Scan timing and per-frame accumulation of low samples (saturating at 2 = MULTI)
  always_comb begin
    sample_en = (div_q == DIV_LAST);
    frame_end = sample_en && (col_idx_q == 2'd3);
    col_lows  = 3'd0;
    col_code  = 4'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2_q[r]) begin
        col_lows = col_lows + 3'd1;
        col_code = key_map(2'(r), col_idx_q);
      end
    end
    lows_sum    = {1'b0, frame_lows_q} + col_lows;
    merged_lows = (lows_sum >= 3'd2) ? 2'd2 : lows_sum[1:0];
    merged_code = (frame_lows_q == 2'd0) ? col_code : frame_code_q;
    res_none    = frame_end && (merged_lows == 2'd0);
    res_single  = frame_end && (merged_lows == 2'd1);

    div_d        = sample_en ? '0 : div_q + 1'b1;
    col_idx_d    = sample_en ? col_idx_q + 2'd1 : col_idx_q;
    frame_lows_d = frame_lows_q;
    frame_code_d = frame_code_q;
    if (sample_en) begin
      frame_lows_d = frame_end ? 2'd0 : merged_lows;
      frame_code_d = frame_end ? 4'd0 : merged_code;
    end
  end

  always_comb begin
    count_inc   = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
    state_d     = state_q;
    cand_d      = cand_q;
    count_d     = count_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (res_single) begin
          state_d = DEBOUNCE;
          cand_d  = merged_code;
          count_d = 8'd1;
        end
      end
      DEBOUNCE: begin
        if (res_single && (merged_code == cand_q)) begin
          count_d = count_inc;
          if (count_inc >= DEB_TARGET) begin
            state_d     = PRESSED;
            key_code_d  = cand_q;
            key_valid_d = 1'b1;
          end
        end else if (frame_end) begin
          state_d = IDLE;
        end
      end
      PRESSED: begin
        if (res_none) begin
          state_d = RELEASE;
          count_d = 8'd1;
        end
      end
      default: begin
        if (res_none) begin
          count_d = count_inc;
          if (count_inc >= DEB_TARGET) state_d = IDLE;
        end else if (frame_end) begin
          state_d = PRESSED;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1_q     <= 4'd0;
      row_s2_q     <= 4'd0;
      div_q        <= '0;
      col_idx_q    <= 2'd0;
      frame_lows_q <= 2'd0;
      frame_code_q <= 4'd0;
      state_q      <= IDLE;
      cand_q       <= 4'd0;
      count_q      <= 8'd0;
      key_code_q   <= 4'd0;
      key_valid_q  <= 1'b0;
    end else begin
      row_s1_q     <= row;
      row_s2_q     <= row_s1_q;
      div_q        <= div_d;
      col_idx_q    <= col_idx_d;
      frame_lows_q <= frame_lows_d;
      frame_code_q <= frame_code_d;
      state_q      <= state_d;
      cand_q       <= cand_d;
      count_q      <= count_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
    end
  end

  always_comb begin
    case (col_idx_q)
      2'd0:    col = 4'b1110;
      2'd1:    col = 4'b1101;
      2'd2:    col = 4'b1011;
      default: col = 4'b0111;
    endcase
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == PRESSED) || (state_q == RELEASE);

`ifdef KEYPAD_DIGIT_ENTRY_EN
  logic [3:0] digit_q [4];
  logic [3:0] digit_d [4];

  // Digits shift one cycle after the key_valid pulse; C clears, letters are ignored
  always_comb begin
    digit_d = digit_q;
    if (key_valid_q) begin
      if (key_code_q <= 4'd9) begin
        digit_d[3] = digit_q[2];
        digit_d[2] = digit_q[1];
        digit_d[1] = digit_q[0];
        digit_d[0] = key_code_q;
      end else if (key_code_q == 4'hC) begin
        for (int i = 0; i < 4; i++) digit_d[i] = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) digit_q[i] <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit0 = digit_q[0];
  assign digit1 = digit_q[1];
  assign digit2 = digit_q[2];
  assign digit3 = digit_q[3];
`else
  assign digit0 = 4'd0;
  assign digit1 = 4'd0;
  assign digit2 = 4'd0;
  assign digit3 = 4'd0;
`endif

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 100000: clk cycles each column is driven (1 ms at 100 MHz).
REQ-002 Parameter DEBOUNCE_SCANS, default 8: consecutive agreeing full frames needed to accept a press or a release; range 2..255.
REQ-003 clk  input  1  100 MHz system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 row  input  4  keypad row lines, active-low, externally pulled up, asynchronous to clk.
REQ-006 col  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 key_code  output  4  hex code of the last accepted key.
REQ-008 key_valid  output  1  one-cycle pulse when a new key is accepted.
REQ-009 key_held  output  1  high while the accepted key remains pressed.
REQ-010 digit0, digit1, digit2, digit3  output  4 each  entered decimal digits for the display driver; digit0 is the most recent.

Function
REQ-011 The block shall synchronize row through a two-flop synchronizer before any use.
REQ-012 The block shall rotate col 1110 -> 1101 -> 1011 -> 0111 -> 1110, holding each pattern for SCAN_DIV cycles; one frame is 4*SCAN_DIV cycles.
REQ-013 The block shall sample synchronized row on the last cycle of each column period.
REQ-014 Key map [row][col]: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = 0,F,E,D.
REQ-015 At frame end, the frame result shall be NONE (no low sample), SINGLE(code) (exactly one low sample), or MULTI (two or more low samples).
REQ-016 FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE; all transitions are evaluated only at frame end.
REQ-017 IDLE: SINGLE(k) -> DEBOUNCE with candidate k and count 1; NONE or MULTI -> stay in IDLE.
REQ-018 DEBOUNCE: SINGLE(candidate) increments count; when count reaches DEBOUNCE_SCANS -> PRESSED, with key_code = candidate and a key_valid pulse in the next cycle. Any other result -> IDLE.
REQ-019 PRESSED: key_held = 1. NONE -> RELEASE with count 1. SINGLE or MULTI -> stay in PRESSED; no new key_valid.
REQ-020 RELEASE: key_held = 1. NONE increments count; when count reaches DEBOUNCE_SCANS -> IDLE with key_held = 0. SINGLE or MULTI -> PRESSED.
REQ-021 key_valid shall never be high for two consecutive cycles; at most one pulse per press.
REQ-022 key_code shall hold its value until the next accepted key.
REQ-023 The count register shall be 8 bits wide and shall saturate (never wrap).

Reset
REQ-024 While rst is low: col = 1110; column timer, frame samples, count and synchronizer = 0; FSM = IDLE; key_code = 0; key_valid = 0; key_held = 0; digit0..digit3 = 0.
REQ-025 Reset asserted mid-frame or mid-debounce shall discard the partial frame; scanning restarts at column 0 one cycle after rst deasserts.

Configuration
REQ-026 Macro KEYPAD_DIGIT_ENTRY_EN defined: on each key_valid with code 0..9, shift digit3 <= digit2, digit2 <= digit1, digit1 <= digit0, digit0 <= code; code C clears all four digits to 0; codes A, B, D, E, F leave the digits unchanged.
REQ-027 Macro KEYPAD_DIGIT_ENTRY_EN undefined: the shift register is not built and digit0..digit3 shall be constant 0; all other behaviour is unchanged.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3)
REQ-028 Idle rows 1111 after reset -> col cycles 1110, 1101, 1011, 0111 every 4 clks; key_valid never pulses; key_held = 0.
REQ-029 Key 5 (row1 low while col=1101) held for 5 frames -> exactly one key_valid pulse at the end of frame 3 plus 1 cycle; key_code = 5; key_held = 1.
REQ-030 Key 7 with a 1-frame bounce (NONE) inside the first 3 frames -> no pulse until 3 consecutive clean frames; then exactly one pulse with key_code = 7.
REQ-031 Keys 1 and 2 pressed together from IDLE -> MULTI, no key_valid; key 1 held, then key 2 added -> held stays 1, no second pulse.
REQ-032 Digit entry (macro on): press 1, 2, 3, 4, 5 -> digit3..digit0 = 2, 3, 4, 5; press C -> all 0. Macro off -> digits stay 0.
REQ-033 rst pulled low during DEBOUNCE count 2 -> all outputs at reset values immediately; after release, a fresh 3 frames are required before key_valid.
